// File: rtl/ahbl_apb_bridge_if.sv
// rtl/ahbl_apb_bridge_if.sv - AHB-Lite / APB3 signal bundle for the AHB-Lite to APB3 bridge
// Purpose: groups the AHB-Lite slave-side and APB3 master-side signals of the bridge.
// Modports:
//   slave  - bridge view: AHB inputs HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY,
//            AHB outputs HREADYOUT/HRESP/HRDATA, APB outputs PADDR/PSEL/PENABLE/PWRITE/PWDATA,
//            APB inputs PRDATA/PREADY/PSLVERR.
//   master - environment view (AHB master plus APB peripheral), directions mirrored.
interface ahbl_apb_bridge_if #(
  parameter int ADDR_W = 16
);
  logic              HSEL;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahbl_apb_bridge.sv
// rtl/ahbl_apb_bridge.sv - AHB-Lite slave to APB3 master bridge, one outstanding word transfer
// Purpose: turns each accepted AHB-Lite word transfer into one APB3 SETUP/ACCESS sequence and
//   returns read data, or a two-cycle AHB ERROR response on PSLVERR or an illegal HSIZE.
// Ports:
//   HCLK    - single clock for both AHB and APB sides
//   HRESETN - synchronous active-low reset
//   bus     - ahbl_apb_bridge_if.slave (AHB-Lite slave side and APB3 master side)
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES
//   cycles without PREADY (ERROR response); undefined, ACCESS waits for PREADY forever.
module ahbl_apb_bridge #(
  parameter int ADDR_W = 16
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input logic              HCLK,
  input logic              HRESETN,
  ahbl_apb_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [31:0]       pwdata_q;
  logic [31:0]       hrdata_q;

  logic hreadyout, hresp, psel, penable;
  logic accept, size_ok, xfer_done, timeout_hit;

  // A new address phase is only taken while this slave drives HREADYOUT=1 (IDLE or ERR2).
  assign accept    = (state_q == S_IDLE || state_q == S_ERR2) &&
                     bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign size_ok   = (bus.HSIZE == 3'b010);
  assign xfer_done = (state_q == S_ACCESS) && bus.PREADY;

`ifdef APB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == S_SETUP) begin
      wait_cnt_d = '0;
    end else if (state_q == S_ACCESS && !bus.PREADY) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign timeout_hit = (state_q == S_ACCESS) && !bus.PREADY && (wait_cnt_q == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        if (accept) begin
          if (!size_ok) begin
            state_d = S_ERR1;
          end else if (bus.HWRITE) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_SETUP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WDATA:  state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (xfer_done) begin
          state_d = bus.PSLVERR ? S_ERR1 : S_IDLE;
        end else if (timeout_hit) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1:   state_d = S_ERR2;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state_q)
      S_WDATA:  hreadyout = 1'b0;
      S_SETUP: begin
        hreadyout = 1'b0;
        psel      = 1'b1;
      end
      S_ACCESS: begin
        hreadyout = 1'b0;
        psel      = 1'b1;
        penable   = 1'b1;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      S_ERR2:   hresp = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers. PADDR/PWRITE load only on accept, which happens with PSEL low,
  // so they are stable for the whole APB sequence.
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      if (accept) begin
        paddr_q  <= bus.HADDR[ADDR_W-1:0];
        pwrite_q <= bus.HWRITE;
      end
      // HWDATA is valid in the data phase, which is the WDATA cycle.
      if (state_q == S_WDATA) begin
        pwdata_q <= bus.HWDATA;
      end
      if (xfer_done && !bus.PSLVERR && !pwrite_q) begin
        hrdata_q <= bus.PRDATA;
      end
    end
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;

  // Upper address bits and HTRANS[0] carry no meaning for this bridge.
  logic unused_bits;
  assign unused_bits = ^{bus.HTRANS[0], bus.HADDR >> ADDR_W};

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// tb/tb_ahbl_apb_bridge.sv - self-checking bench for ahbl_apb_bridge
module tb_ahbl_apb_bridge;

  localparam int ADDR_W = 16;

  logic HCLK = 1'b0;
  logic HRESETN = 1'b0;

  always #5 HCLK = ~HCLK;

  ahbl_apb_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  ahbl_apb_bridge #(
    .ADDR_W(ADDR_W)
`ifdef APB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .HCLK   (HCLK),
    .HRESETN(HRESETN),
    .bus    (bus)
  );

  assign bus.HREADY = bus.HREADYOUT;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // APB peripheral: word memory, configurable wait states and error per transfer.
  logic [31:0] slave_mem [0:63];
  bit preloaded = 1'b0;
  int acc_cnt = 0;
  int cfg_waits = 0;
  bit cfg_err = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A4_FFFD + 32'(i);
  endfunction

  always @(negedge HCLK) begin
    if (!preloaded) begin
      for (int i = 0; i < 64; i++) slave_mem[i] = init_word(i);
      preloaded = 1'b1;
    end
    if (bus.PSEL && bus.PENABLE) begin
      if (acc_cnt >= cfg_waits) begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = cfg_err;
        bus.PRDATA  = bus.PWRITE ? $urandom : slave_mem[bus.PADDR[7:2]];
        if (bus.PWRITE && !cfg_err) slave_mem[bus.PADDR[7:2]] = bus.PWDATA;
      end else begin
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'($urandom);
        bus.PRDATA  = $urandom;
      end
      acc_cnt++;
    end else begin
      bus.PREADY  = 1'b0;
      bus.PSLVERR = 1'b0;
      bus.PRDATA  = $urandom;
      acc_cnt     = 0;
    end
  end

  // Reference model: memory contents and last successfully read word.
  logic [31:0] ref_mem [0:63];
  logic [31:0] ref_rdata;

  task automatic ref_apply(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] size, input bit err);
    if (size == 3'b010 && !err) begin
      if (wr) ref_mem[addr[7:2]] = wdata;
      else ref_rdata = ref_mem[addr[7:2]];
    end
  endtask

  // One AHB transfer from address phase to the end of its response; returns just after
  // the edge that ends the response cycle.
  task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, output logic resp, output logic resp_lead,
                          output logic [31:0] rdata, output int low, output int psel_n,
                          output int pen_n, output int psel_first, output int pen_first,
                          output logic apb_ok);
    int cyc;
    bit done;
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    bus.HWDATA = $urandom;
    @(posedge HCLK); #1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HADDR  = $urandom;
    bus.HWRITE = 1'($urandom);
    bus.HWDATA = wdata;
    resp = 1'b0; resp_lead = 1'b0; rdata = '0;
    low = 0; psel_n = 0; pen_n = 0; psel_first = -1; pen_first = -1;
    apb_ok = 1'b1; cyc = 1; done = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge HCLK);
      if (bus.PSEL) begin
        psel_n++;
        if (psel_first < 0) psel_first = cyc;
        if (bus.PADDR !== addr[ADDR_W-1:0] || bus.PWRITE !== wr ||
            (wr && bus.PWDATA !== wdata)) apb_ok = 1'b0;
      end
      if (bus.PENABLE) begin
        pen_n++;
        if (pen_first < 0) pen_first = cyc;
        if (!bus.PSEL) apb_ok = 1'b0;
      end
      if (bus.HREADYOUT) begin
        done  = 1'b1;
        resp  = bus.HRESP;
        rdata = bus.HRDATA;
      end else begin
        low++;
        resp_lead = bus.HRESP;
      end
      @(posedge HCLK); #1;
      cyc++;
    end
    check("xfer_completed", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    int          waits;
    bit          err;
    logic        exp_resp;
    int          exp_low;
    logic [31:0] exp_rdata;
    int          exp_psel;
    int          exp_pen;
    int          exp_psel_first;
  } vec_t;

  vec_t vecs [12];

  logic        r_resp, r_lead, r_ok;
  logic [31:0] r_rdata;
  int          r_low, r_psel, r_pen, r_pfirst, r_efirst;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           wr    addr          wdata         size    w  e  resp  low rdata         psel pen first
    vecs[0]  = '{1'b1, 32'h0000_0004, 32'h0000_0055, 3'b010, 0, 0, 1'b0, 3, 32'h0000_0000, 2, 1, 2};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 0, 0, 1'b0, 2, 32'hA5A5_0001, 2, 1, 1};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 5, 0, 1'b0, 7, 32'hA5A5_0001, 7, 6, 1};
    vecs[3]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 3'b010, 0, 1, 1'b1, 4, 32'hA5A5_0001, 2, 1, 2};
    vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0,         3'b010, 0, 0, 1'b0, 2, 32'h0000_0055, 2, 1, 1};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         3'b001, 0, 0, 1'b1, 1, 32'h0000_0055, 0, 0, -1};
    vecs[6]  = '{1'b0, 32'h0000_0008, 32'h0,         3'b010, 0, 0, 1'b0, 2, 32'hA5A4_FFFF, 2, 1, 1};
    vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 2, 1, 1'b1, 5, 32'hA5A4_FFFF, 4, 3, 1};
    vecs[8]  = '{1'b1, 32'h0000_000C, 32'h0000_0077, 3'b000, 0, 0, 1'b1, 1, 32'hA5A4_FFFF, 0, 0, -1};
    vecs[9]  = '{1'b0, 32'h0000_000C, 32'h0,         3'b010, 0, 0, 1'b0, 2, 32'hA5A5_0000, 2, 1, 1};
    vecs[10] = '{1'b1, 32'h0000_003C, 32'h0BAD_F00D, 3'b010, 1, 0, 1'b0, 4, 32'hA5A5_0000, 3, 2, 2};
    vecs[11] = '{1'b0, 32'h0000_003C, 32'h0,         3'b010, 0, 0, 1'b0, 2, 32'h0BAD_F00D, 2, 1, 1};

    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    ref_rdata = '0;

    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b010; bus.HWDATA = '0;

    // Reset state
    HRESETN = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("rst_hresp",     32'(bus.HRESP),     32'd0);
    check("rst_hrdata",    bus.HRDATA,         32'd0);
    check("rst_psel",      32'(bus.PSEL),      32'd0);
    check("rst_penable",   32'(bus.PENABLE),   32'd0);
    check("rst_pwrite",    32'(bus.PWRITE),    32'd0);
    check("rst_paddr",     32'(bus.PADDR),     32'd0);
    check("rst_pwdata",    bus.PWDATA,         32'd0);
    @(posedge HCLK); #1;
    HRESETN = 1'b1;
    @(posedge HCLK); #1;

    // Directed vectors
    for (int v = 0; v < 12; v++) begin
      cfg_waits = vecs[v].waits;
      cfg_err   = vecs[v].err;
      ahb_xfer(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].size,
               r_resp, r_lead, r_rdata, r_low, r_psel, r_pen, r_pfirst, r_efirst, r_ok);
      ref_apply(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].size, vecs[v].err);
      check($sformatf("vec%0d_hresp", v),      32'(r_resp),  32'(vecs[v].exp_resp));
      check($sformatf("vec%0d_hresp_lead", v), 32'(r_lead),  32'(vecs[v].exp_resp));
      check($sformatf("vec%0d_wait_cycles", v), 32'(r_low),  32'(vecs[v].exp_low));
      check($sformatf("vec%0d_hrdata", v),     r_rdata,      vecs[v].exp_rdata);
      check($sformatf("vec%0d_psel_cycles", v), 32'(r_psel), 32'(vecs[v].exp_psel));
      check($sformatf("vec%0d_penable_cycles", v), 32'(r_pen), 32'(vecs[v].exp_pen));
      check($sformatf("vec%0d_psel_first", v), 32'(r_pfirst), 32'(vecs[v].exp_psel_first));
      check($sformatf("vec%0d_penable_first", v), 32'(r_efirst),
            32'(vecs[v].exp_psel_first < 0 ? -1 : vecs[v].exp_psel_first + 1));
      check($sformatf("vec%0d_apb_stable", v), 32'(r_ok), 32'd1);
    end

    // IDLE and BUSY transfers are ignored with OKAY
    bus.HSEL = 1'b1;
    bus.HSIZE = 3'b010;
    for (int i = 0; i < 4; i++) begin
      bus.HTRANS = (i < 2) ? 2'b00 : 2'b01;
      bus.HADDR  = $urandom;
      bus.HWRITE = 1'($urandom);
      @(posedge HCLK); #1;
      @(negedge HCLK);
      check($sformatf("idle_busy_%0d", i), {29'd0, bus.HREADYOUT, bus.HRESP, bus.PSEL}, 32'b100);
    end
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0;
    bus.HTRANS = 2'b00;

    // Reset while in ACCESS aborts the transfer
    cfg_waits = 10;
    cfg_err   = 1'b0;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h10; bus.HWRITE = 1'b0; bus.HSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    for (int k = 0; k < 20 && !bus.PENABLE; k++) begin
      @(posedge HCLK); #1;
    end
    check("rstmid_reached_access", 32'(bus.PENABLE), 32'd1);
    @(posedge HCLK); #1;
    HRESETN = 1'b0;
    @(posedge HCLK); #1;
    check("rstmid_psel",      32'(bus.PSEL),      32'd0);
    check("rstmid_penable",   32'(bus.PENABLE),   32'd0);
    check("rstmid_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("rstmid_hrdata",    bus.HRDATA,         32'd0);
    HRESETN = 1'b1;
    ref_rdata = '0;
    @(posedge HCLK); #1;

`ifdef APB_TIMEOUT_EN
    // Peripheral never answers: 8 ACCESS cycles then a two-cycle ERROR
    cfg_waits = 1000;
    cfg_err   = 1'b0;
    ahb_xfer(1'b0, 32'h10, 32'h0, 3'b010,
             r_resp, r_lead, r_rdata, r_low, r_psel, r_pen, r_pfirst, r_efirst, r_ok);
    check("timeout_hresp",   32'(r_resp), 32'd1);
    check("timeout_lead",    32'(r_lead), 32'd1);
    check("timeout_penable", 32'(r_pen),  32'd8);
    check("timeout_wait",    32'(r_low),  32'd10);
    check("timeout_hrdata",  r_rdata,     ref_rdata);
`endif

    // Randomized transfers against the reference model
    for (int t = 0; t < 40; t++) begin
      logic        wr;
      logic [31:0] addr, wdata;
      logic [2:0]  size;
      int          waits, exp_low, exp_psel;
      bit          err, bad;
      wr    = 1'($urandom);
      addr  = $urandom;
      addr[1:0] = 2'b00;
      wdata = $urandom;
      size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 1)) : 3'b010;
      waits = $urandom_range(0, 3);
      err   = ($urandom_range(0, 4) == 0);
      bad   = (size != 3'b010);
      cfg_waits = waits;
      cfg_err   = err;
      ahb_xfer(wr, addr, wdata, size,
               r_resp, r_lead, r_rdata, r_low, r_psel, r_pen, r_pfirst, r_efirst, r_ok);
      ref_apply(wr, addr, wdata, size, err);
      exp_low  = bad ? 1 : (wr ? 3 : 2) + waits + (err ? 1 : 0);
      exp_psel = bad ? 0 : waits + 2;
      check($sformatf("rnd%0d_hresp", t),  32'(r_resp), 32'(bad || err));
      check($sformatf("rnd%0d_lead", t),   32'(r_lead), 32'(bad || err));
      check($sformatf("rnd%0d_wait", t),   32'(r_low),  32'(exp_low));
      check($sformatf("rnd%0d_hrdata", t), r_rdata,     ref_rdata);
      check($sformatf("rnd%0d_psel", t),   32'(r_psel), 32'(exp_psel));
      check($sformatf("rnd%0d_apb", t),    32'(r_ok),   32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
